// File: rtl/sm_mem_responder.sv
// SM L1 memory-port responder: block-granular backing store behind
// TileLink-UL-style A/D channels with an in-order, fixed-latency response queue.
module sm_mem_responder #(
   parameter int XLEN        = 32,
   parameter int BLOCKWORDS  = 16,
   parameter int BYTESOFWORD = 4,
   parameter int SOURCE_W    = 6,
   parameter int MEM_DEPTH   = 64,
   parameter int QDEPTH      = 4,
   parameter int LATENCY     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          a_valid_i,
   output logic                          a_ready_o,
   input  logic [2:0]                    a_opcode_i,
   input  logic [2:0]                    a_param_i,
   input  logic [XLEN-1:0]               a_addr_i,
   input  logic [BLOCKWORDS*XLEN-1:0]    a_data_i,
   input  logic [BLOCKWORDS*BYTESOFWORD-1:0] a_mask_i,
   input  logic [SOURCE_W-1:0]           a_source_i,
   output logic                          d_valid_o,
   input  logic                          d_ready_i,
   output logic [2:0]                    d_opcode_o,
   output logic [XLEN-1:0]               d_addr_o,
   output logic [BLOCKWORDS*XLEN-1:0]    d_data_o,
   output logic [SOURCE_W-1:0]           d_source_o,
   output logic                          err_o,
   output logic [$clog2(QDEPTH):0]       outstanding_o
);

   localparam int BW  = BLOCKWORDS * XLEN;
   localparam int NB  = BLOCKWORDS * BYTESOFWORD;
   localparam int BYW = XLEN / BYTESOFWORD;
   localparam int OFF = $clog2(NB);
   localparam int MW  = $clog2(MEM_DEPTH);
   localparam int QW  = $clog2(QDEPTH);
   localparam int TW  = $clog2(LATENCY + 1);

   localparam logic [2:0] OP_PUTF = 3'd0;
   localparam logic [2:0] OP_PUTP = 3'd1;
   localparam logic [2:0] OP_GET  = 3'd4;
   localparam logic [2:0] OP_ACK  = 3'd0;
   localparam logic [2:0] OP_ACKD = 3'd1;

   logic [BW-1:0]       mem    [MEM_DEPTH];
   logic [2:0]          q_op   [QDEPTH];
   logic [XLEN-1:0]     q_addr [QDEPTH];
   logic [BW-1:0]       q_data [QDEPTH];
   logic [SOURCE_W-1:0] q_src  [QDEPTH];
   logic [TW-1:0]       q_tmr  [QDEPTH];

   logic [QW-1:0] head, tail, head_n;
   logic [QW:0]   cnt, cnt_n;
   logic          d_valid, err, valid_n;
   logic          push, pop, is_get, supported;
   logic [MW-1:0] idx;
   logic          unused_param;

   assign unused_param = ^a_param_i;

   assign idx       = a_addr_i[OFF +: MW];
   assign a_ready_o = cnt < (QW+1)'(QDEPTH);
   assign push      = a_valid_i && a_ready_o;
   assign pop       = d_valid && d_ready_i;
   assign is_get    = a_opcode_i == OP_GET;
   assign supported = is_get || a_opcode_i == OP_PUTF
                      || a_opcode_i == OP_PUTP;

   // A freshly pushed entry becoming head must age a full LATENCY first.
   always_comb begin
      head_n  = pop ? head + QW'(1) : head;
      cnt_n   = cnt + (QW+1)'(push) - (QW+1)'(pop);
      valid_n = (cnt_n != '0) && (q_tmr[head_n] == '0)
                && !(push && head_n == tail);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         for (int b = 0; b < NB; b++) begin
            if (a_opcode_i == OP_PUTF
                || (a_opcode_i == OP_PUTP && a_mask_i[b]))
               mem[idx][b*BYW +: BYW] <= a_data_i[b*BYW +: BYW];
         end
         q_op[tail]   <= is_get ? OP_ACKD : OP_ACK;
         q_addr[tail] <= a_addr_i;
         q_data[tail] <= is_get ? mem[idx] : '0;
         q_src[tail]  <= a_source_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         cnt     <= '0;
         d_valid <= 1'b0;
         err     <= 1'b0;
         for (int i = 0; i < QDEPTH; i++)
            q_tmr[i] <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (q_tmr[i] != '0)
               q_tmr[i] <= q_tmr[i] - TW'(1);
         end
         if (push) begin
            q_tmr[tail] <= TW'(LATENCY - 1);
            tail        <= tail + QW'(1);
         end
         head    <= head_n;
         cnt     <= cnt_n;
         d_valid <= valid_n;
         err     <= push && !supported;
      end
   end

   assign d_valid_o     = d_valid;
   assign d_opcode_o    = q_op[head];
   assign d_addr_o      = q_addr[head];
   assign d_data_o      = q_data[head];
   assign d_source_o    = q_src[head];
   assign err_o         = err;
   assign outstanding_o = cnt;

endmodule
